// File: rtl/probe_activity_monitor.sv
// Multi-channel probe activity monitor: flags probe bits that never toggle within a
// sampling window and reports per-channel idle mask and saturating toggle count.
module probe_activity_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en_i,
  input  logic                                          clear_i,
  input  logic [NUM_CH*WIDTH-1:0]                       probe_i,
  output logic                                          rd_valid_o,
  input  logic                                          rd_ready_i,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch_o,
  output logic [WIDTH-1:0]                              rd_idle_mask_o,
  output logic [CNT_W-1:0]                              rd_toggle_cnt_o,
  output logic                                          window_done_o,
  output logic                                          busy_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WIN_W = $clog2(WINDOW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_SAMPLE,
    S_DUMP
  } state_t;

  state_t                    r_state;
  logic [NUM_CH*WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]          r_tmask       [NUM_CH];
  logic [CNT_W-1:0]          r_cnt         [NUM_CH];
  logic [WIDTH-1:0]          r_shadow_mask [NUM_CH];
  logic [CNT_W-1:0]          r_shadow_cnt  [NUM_CH];
  logic [WIN_W-1:0]          r_win;
  logic [CH_W-1:0]           r_beat;
  logic                      r_valid;
  logic                      r_done;

  logic [NUM_CH*WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]          w_tmask_nxt [NUM_CH];
  logic [CNT_W-1:0]          w_pop       [NUM_CH];
  logic [CNT_W:0]            w_sum       [NUM_CH];
  logic [CNT_W-1:0]          w_cnt_nxt   [NUM_CH];
  logic                      w_win_last;
  logic                      w_beat_last;

  // Sum is one bit wider than the counter so an overflow can be detected and clamped.
  always_comb begin
    w_diff = probe_i ^ r_prev;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_tmask_nxt[c] = r_tmask[c] | w_diff[c*WIDTH +: WIDTH];
      w_pop[c]       = '0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
        w_pop[c] = w_pop[c] + CNT_W'(w_diff[c*WIDTH + b]);
      end
      w_sum[c]     = {1'b0, r_cnt[c]} + {1'b0, w_pop[c]};
      w_cnt_nxt[c] = w_sum[c][CNT_W] ? '1 : w_sum[c][CNT_W-1:0];
    end
  end

  assign w_win_last  = (r_win == WIN_W'(WINDOW - 1));
  assign w_beat_last = (r_beat == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_win   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_tmask[c]       <= '0;
        r_cnt[c]         <= '0;
        r_shadow_mask[c] <= '0;
        r_shadow_cnt[c]  <= '0;
      end
    end else if (clear_i) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_win   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_tmask[c]       <= '0;
        r_cnt[c]         <= '0;
        r_shadow_mask[c] <= '0;
        r_shadow_cnt[c]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en_i) r_state <= S_PRIME;
        end
        S_PRIME: begin
          r_prev  <= probe_i;
          r_win   <= '0;
          r_state <= S_SAMPLE;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_tmask[c] <= '0;
            r_cnt[c]   <= '0;
          end
        end
        S_SAMPLE: begin
          if (!en_i) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              r_tmask[c] <= '0;
              r_cnt[c]   <= '0;
            end
          end else begin
            r_prev <= probe_i;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              r_tmask[c] <= w_tmask_nxt[c];
              r_cnt[c]   <= w_cnt_nxt[c];
            end
            if (w_win_last) begin
              // Final pair is folded straight into the shadows, not via the accumulators.
              for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_shadow_mask[c] <= ~w_tmask_nxt[c];
                r_shadow_cnt[c]  <= w_cnt_nxt[c];
              end
              r_done  <= 1'b1;
              r_valid <= 1'b1;
              r_beat  <= '0;
              r_state <= S_DUMP;
            end else begin
              r_win <= r_win + WIN_W'(1);
            end
          end
        end
        S_DUMP: begin
          if (rd_ready_i) begin
            if (w_beat_last) begin
              r_valid <= 1'b0;
              r_beat  <= '0;
              r_state <= en_i ? S_PRIME : S_IDLE;
            end else begin
              r_beat <= r_beat + CH_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid_o      = r_valid;
  assign window_done_o   = r_done;
  assign rd_ch_o         = r_beat;
  assign rd_idle_mask_o  = r_valid ? r_shadow_mask[r_beat] : '0;
  assign rd_toggle_cnt_o = r_valid ? r_shadow_cnt[r_beat] : '0;
  assign busy_o          = (r_state != S_IDLE);

endmodule

// File: doc/probe_activity_monitor.md
Name: probe_activity_monitor

Overview:
- Parametrised multi-channel debug-probe monitor; detects probe bits that never toggle (unused or stuck) in a programmable sampling window.
- Per-channel sticky toggle mask and saturating toggle count are accumulated over the window, snapshotted, then drained one channel per beat over a valid/ready readout port.
- Sits beside debug/test logic. Raw probes are observed only and never driven.

Parameters:
NUM_CH, 4, number of probe channels (>=1)
WIDTH, 8, bits per channel (>=1)
WINDOW, 256, sampling cycles per window (>=2)
CNT_W, 16, toggle-counter width per channel (>= $clog2(WIDTH+1))

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en_i  in  1  monitoring enable (level)
clear_i  in  1  synchronous clear, highest priority after reset
probe_i  in  NUM_CH*WIDTH  probe bus; channel c = probe_i[c*WIDTH +: WIDTH]
rd_valid_o  out  1  readout beat valid
rd_ready_i  in  1  readout consumer ready
rd_ch_o  out  max(1,$clog2(NUM_CH))  channel index of current beat
rd_idle_mask_o  out  WIDTH  bits of rd_ch_o that never toggled in the window (1 = idle)
rd_toggle_cnt_o  out  CNT_W  total bit toggles of rd_ch_o in the window, saturating
window_done_o  out  1  one-cycle pulse when a window closes
busy_o  out  1  high in PRIME, SAMPLE or DUMP

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. Window counter, masks, counters and shadows are 0.
- The FSM has four states: IDLE, PRIME, SAMPLE and DUMP.
- IDLE: when en_i=1, go to PRIME.
- PRIME (1 cycle): capture probe_i into prev and clear the accumulators. The window counter is set to 0. Then go to SAMPLE.
- SAMPLE, each cycle:
  - diff = probe_i ^ prev; prev <= probe_i.
  - Per channel, tmask |= diff_c.
  - cnt_c += popcount(diff_c), saturating at 2^CNT_W-1.
  - The window counter increments.
  - On the cycle with counter == WINDOW-1, that cycle's diff is included. Then:
    - shadow_mask_c <= ~(tmask_c | diff_c)
    - shadow_cnt_c <= the final saturated sum
    - window_done_o pulses the next cycle
    - next state is DUMP with beat index 0.
  - So the window covers exactly WINDOW compared sample pairs.
- en_i=0 in SAMPLE: abort. Go to IDLE next cycle; no window_done_o, no DUMP, accumulators discarded.
- DUMP:
  - rd_valid_o=1 and rd_ch_o=beat, with shadow data for that channel.
  - Outputs stay stable while rd_valid_o && !rd_ready_i.
  - On handshake, beat increments.
  - On the handshake of beat NUM_CH-1, rd_valid_o drops the next cycle. Next state is PRIME if en_i=1, else IDLE.
  - Probes are not sampled during DUMP or PRIME; there is a gap between windows.
  - en_i falling in DUMP does not abort the drain.
- clear_i=1 in any state:
  - next state is IDLE
  - rd_valid_o=0, window_done_o=0
  - all accumulators, shadows and counters are 0.
  - clear_i wins over en_i and over a simultaneous handshake.
- busy_o is combinational from state.
- rd_* data are registered shadows, so no combinational path exists from probe_i to the outputs.
- Reset mid-DUMP discards the pending beats; after release the block is in IDLE.
- The counter saturates and never wraps: once at max, further toggles keep it at max.

Test Plan:
- NUM_CH=2, WIDTH=4, WINDOW=8. Hold probe=0, en=1 → window_done pulse. Beats ch0, ch1 each idle_mask=4'hF, cnt=0.
- Same config. Ch0 bit0 toggles every cycle, other bits constant, ch1 constant → ch0 idle_mask=4'hE, cnt=8; ch1 mask=4'hF, cnt=0.
- CNT_W=3, WIDTH=4. All 4 ch0 bits toggle every cycle for 8 cycles (raw 32) → cnt=7 (saturated).
- rd_ready held 0 for 5 cycles in DUMP → rd_valid stays 1 and data/ch stable. Then ready=1 → 2 beats, valid drops, PRIME follows (en=1).
- en dropped at SAMPLE counter=3 → IDLE; no window_done or rd_valid. Clear asserted during a DUMP beat with ready=1 → IDLE and all outputs 0 next cycle.
- rst_n asserted asynchronously mid-SAMPLE → outputs 0 immediately. After release with en=1, PRIME, then a full fresh window.
